// File: rtl/counter_pkg.sv
// Shared types and defaults for the up/down counter and its checker.
// Both the RTL checker and the counter bench scoreboard use these.
package counter_pkg;

    typedef enum logic {
        SYNC  = 1'b0,
        TRACK = 1'b1
    } chk_state_t;

    localparam int COUNTER_WIDTH     = 8;
    localparam int COUNTER_RESET_VAL = 0;

endpackage

// File: rtl/counter_checker_if.sv
// Monitor-side bundle: observed counter activity in, checker verdicts out.
interface counter_checker_if
    import counter_pkg::*;
#(
    parameter int WIDTH     = COUNTER_WIDTH,
    parameter int ERR_CNT_W = 8
);

    logic                 mon_rst;
    logic                 mon_enable;
    logic                 mon_direction;
    logic [WIDTH-1:0]     mon_count;
    logic                 clear;

    logic                 synced;
    logic [WIDTH-1:0]     expected;
    logic                 err;
    logic                 err_pulse;
    logic [ERR_CNT_W-1:0] err_count;
    logic                 wrap_up;
    logic                 wrap_down;

    modport master (
        output mon_rst, mon_enable, mon_direction, mon_count, clear,
        input  synced, expected, err, err_pulse, err_count, wrap_up, wrap_down
    );

    modport slave (
        input  mon_rst, mon_enable, mon_direction, mon_count, clear,
        output synced, expected, err, err_pulse, err_count, wrap_up, wrap_down
    );

endinterface

// File: rtl/counter_ref_model.sv
// Combinational one-step model of the up/down counter, with wrap detection.
// Reset overrides enable; arithmetic is modulo 2^WIDTH.
module counter_ref_model
    import counter_pkg::*;
#(
    parameter int               WIDTH     = COUNTER_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(COUNTER_RESET_VAL)
) (
    input  logic [WIDTH-1:0] base_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             direction_i,
    output logic [WIDTH-1:0] next_o,
    output logic             wrap_up_o,
    output logic             wrap_down_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    always_comb begin
        next_o      = base_i;
        wrap_up_o   = 1'b0;
        wrap_down_o = 1'b0;
        if (rst_i) begin
            next_o = RESET_VAL;
        end else if (enable_i) begin
            if (direction_i) begin
                next_o    = base_i + ONE;
                wrap_up_o = &base_i;
            end else begin
                next_o      = base_i - ONE;
                wrap_down_o = ~|base_i;
            end
        end
    end

endmodule

// File: rtl/counter_checker.sv
// Passive checker: tracks the observed counter with a reference model and
// flags, counts and optionally resynchronises on every mismatch.
module counter_checker
    import counter_pkg::*;
#(
    parameter int WIDTH         = COUNTER_WIDTH,
    parameter int ERR_CNT_W     = 8,
    parameter int RESET_VAL     = COUNTER_RESET_VAL,
    parameter int RESYNC_ON_ERR = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    counter_checker_if.slave  bus
);

    localparam logic [WIDTH-1:0]     RESET_Q = WIDTH'(RESET_VAL);
    localparam logic [ERR_CNT_W-1:0] ERR_ONE = ERR_CNT_W'(1);

    chk_state_t           state_q, state_d;
    logic [WIDTH-1:0]     expected_q, expected_d;
    logic                 err_q, err_d;
    logic                 err_pulse_q, err_pulse_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
    logic                 wrap_up_q, wrap_up_d;
    logic                 wrap_down_q, wrap_down_d;

    logic                 mismatch;
    logic [WIDTH-1:0]     base;
    logic [WIDTH-1:0]     model_next;
    logic                 model_wrap_up;
    logic                 model_wrap_down;

    // The compare also runs on mon_rst edges: the pre-reset count must be right too.
    assign mismatch = (state_q == TRACK) && (bus.mon_count != expected_q);
    assign base     = (mismatch && (RESYNC_ON_ERR != 0)) ? bus.mon_count : expected_q;

    counter_ref_model #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_Q)
    ) u_ref_model (
        .base_i      (base),
        .rst_i       (bus.mon_rst),
        .enable_i    (bus.mon_enable),
        .direction_i (bus.mon_direction),
        .next_o      (model_next),
        .wrap_up_o   (model_wrap_up),
        .wrap_down_o (model_wrap_down)
    );

    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        err_d       = err_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;
        wrap_up_d   = 1'b0;
        wrap_down_d = 1'b0;

        case (state_q)
            SYNC: begin
                if (bus.mon_rst) begin
                    state_d    = TRACK;
                    expected_d = RESET_Q;
                end
            end
            TRACK: begin
                expected_d  = model_next;
                wrap_up_d   = model_wrap_up;
                wrap_down_d = model_wrap_down;
                err_pulse_d = mismatch;
            end
        endcase

        // A mismatch on the same edge as clear still gets recorded.
        if (mismatch) begin
            err_d = 1'b1;
            if (bus.clear) begin
                err_count_d = ERR_ONE;
            end else if (!(&err_count_q)) begin
                err_count_d = err_count_q + ERR_ONE;
            end
        end else if (bus.clear) begin
            err_d       = 1'b0;
            err_count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SYNC;
            expected_q  <= RESET_Q;
            err_q       <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
            wrap_up_q   <= 1'b0;
            wrap_down_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            err_q       <= err_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
            wrap_up_q   <= wrap_up_d;
            wrap_down_q <= wrap_down_d;
        end
    end

    assign bus.synced    = (state_q == TRACK);
    assign bus.expected  = expected_q;
    assign bus.err       = err_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_count = err_count_q;
    assign bus.wrap_up   = wrap_up_q;
    assign bus.wrap_down = wrap_down_q;

endmodule
